// File: rtl/control_sequencer_if.sv
// Bundle of instruction/flag inputs and datapath control lines between the
// sequencer and the rest of the CPU.
interface control_sequencer_if;
  logic       run;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;
  logic       hlt, mi, ri, ro, io, ii, ai, ao;
  logic       eo, su, bi, oi, ce, co, j, fi;
  logic [2:0] step;
  logic       halted;

  modport master (
    output run, opcode, flag_c, flag_z,
    input  hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi,
    input  step, halted
  );

  modport slave (
    input  run, opcode, flag_c, flag_z,
    output hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi,
    output step, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Microstep sequencer for an 8-bit breadboard-style CPU: 5-step instruction
// cycle with combinational control-line decode and a sticky halt.
module control_sequencer #(
  parameter bit EARLY_END = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  control_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    STEP0 = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4
  } step_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'he,
    OP_HLT = 4'hf
  } opcode_e;

  typedef struct packed {
    logic hlt, mi, ri, ro, io, ii, ai, ao;
    logic eo, su, bi, oi, ce, co, j, fi;
  } ctrl_t;

  step_e step_q, step_d, last_step;
  logic  halted_q, halted_d;
  logic  active;
  ctrl_t ctrl;

  assign active = rst_n & bus.run & ~halted_q;

  always_comb begin
    last_step = STEP2;
    case (bus.opcode)
      OP_LDA, OP_STA: last_step = STEP3;
      OP_ADD, OP_SUB: last_step = STEP4;
      default:        last_step = STEP2;
    endcase
  end

  // Halt freezes the counter at step 2; only reset leaves the halted state.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (bus.run && !halted_q) begin
      if (step_q == STEP2 && bus.opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q == STEP4 || (EARLY_END && step_q == last_step)) begin
        step_d = STEP0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= STEP0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ctrl = '0;
    case (step_q)
      STEP0: begin
        ctrl.co = 1'b1;
        ctrl.mi = 1'b1;
      end
      STEP1: begin
        ctrl.ro = 1'b1;
        ctrl.ii = 1'b1;
        ctrl.ce = 1'b1;
      end
      STEP2: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.io = 1'b1;
            ctrl.mi = 1'b1;
          end
          OP_LDI: begin
            ctrl.io = 1'b1;
            ctrl.ai = 1'b1;
          end
          OP_JMP: begin
            ctrl.io = 1'b1;
            ctrl.j  = 1'b1;
          end
          OP_JC: begin
            ctrl.io = bus.flag_c;
            ctrl.j  = bus.flag_c;
          end
          OP_JZ: begin
            ctrl.io = bus.flag_z;
            ctrl.j  = bus.flag_z;
          end
          OP_OUT: begin
            ctrl.ao = 1'b1;
            ctrl.oi = 1'b1;
          end
          OP_HLT:  ctrl.hlt = 1'b1;
          default: ctrl = '0;
        endcase
      end
      STEP3: begin
        case (bus.opcode)
          OP_LDA: begin
            ctrl.ro = 1'b1;
            ctrl.ai = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ro = 1'b1;
            ctrl.bi = 1'b1;
          end
          OP_STA: begin
            ctrl.ao = 1'b1;
            ctrl.ri = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      STEP4: begin
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          ctrl.eo = 1'b1;
          ctrl.ai = 1'b1;
          ctrl.fi = 1'b1;
          ctrl.su = (bus.opcode == OP_SUB);
        end
      end
      default: ctrl = '0;
    endcase
    // A stalled or halted step must never re-issue a RAM write or jump.
    if (!active) ctrl = '0;
  end

  assign bus.hlt    = ctrl.hlt;
  assign bus.mi     = ctrl.mi;
  assign bus.ri     = ctrl.ri;
  assign bus.ro     = ctrl.ro;
  assign bus.io     = ctrl.io;
  assign bus.ii     = ctrl.ii;
  assign bus.ai     = ctrl.ai;
  assign bus.ao     = ctrl.ao;
  assign bus.eo     = ctrl.eo;
  assign bus.su     = ctrl.su;
  assign bus.bi     = ctrl.bi;
  assign bus.oi     = ctrl.oi;
  assign bus.ce     = ctrl.ce;
  assign bus.co     = ctrl.co;
  assign bus.j      = ctrl.j;
  assign bus.fi     = ctrl.fi;
  assign bus.step   = step_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance per EARLY_END setting,
// expected steps and control words hand-derived from the opcode table.
module tb_control_sequencer;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;
  localparam logic [15:0] NONE = 16'h0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  control_sequencer_if if0 ();
  control_sequencer_if if1 ();

  control_sequencer #(.EARLY_END(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  control_sequencer #(.EARLY_END(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [15:0] ctl0, ctl1;
  assign ctl0 = {if0.hlt, if0.mi, if0.ri, if0.ro, if0.io, if0.ii, if0.ai, if0.ao,
                 if0.eo, if0.su, if0.bi, if0.oi, if0.ce, if0.co, if0.j, if0.fi};
  assign ctl1 = {if1.hlt, if1.mi, if1.ri, if1.ro, if1.io, if1.ii, if1.ai, if1.ao,
                 if1.eo, if1.su, if1.bi, if1.oi, if1.ce, if1.co, if1.j, if1.fi};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.run = 1'b1; if0.opcode = 4'h2; if0.flag_c = 1'b0; if0.flag_z = 1'b0;
    if1.run = 1'b0; if1.opcode = 4'h0; if1.flag_c = 1'b0; if1.flag_z = 1'b0;
    #1;
    checks++; if (if0.step !== 3'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", if0.step); end
    checks++; if (if0.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", if0.halted); end
    checks++; if (ctl0 !== NONE) begin errors++; $display("FAIL reset_ctl: got %h expected %h", ctl0, NONE); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (if0.step !== 3'd0) begin errors++; $display("FAIL release_step: got %0d expected 0", if0.step); end
    checks++; if (ctl0 !== (CO | MI)) begin errors++; $display("FAIL release_ctl: got %h expected %h", ctl0, CO | MI); end
  endtask

  task automatic test_add();
    logic [2:0]  es [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [15:0] ec [5] = '{RO | II | CE, IO | MI, RO | BI, EO | AI | FI, CO | MI};
    for (int i = 0; i < 5; i++) begin
      advance();
      checks++; if (if0.step !== es[i]) begin errors++; $display("FAIL add_step[%0d]: got %0d expected %0d", i, if0.step, es[i]); end
      checks++; if (ctl0 !== ec[i]) begin errors++; $display("FAIL add_ctl[%0d]: got %h expected %h", i, ctl0, ec[i]); end
    end
  endtask

  task automatic test_opcodes();
    logic [3:0]  op [8] = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'he, 4'h0, 4'hb};
    logic [15:0] e2 [8] = '{IO | MI, IO | MI, IO | MI, IO | AI, IO | J, AO | OI, NONE, NONE};
    logic [15:0] e3 [8] = '{RO | AI, RO | BI, AO | RI, NONE, NONE, NONE, NONE, NONE};
    logic [15:0] e4 [8] = '{NONE, EO | AI | FI | SU, NONE, NONE, NONE, NONE, NONE, NONE};
    for (int i = 0; i < 8; i++) begin
      if0.opcode = op[i];
      advance();
      advance();
      checks++; if (ctl0 !== e2[i]) begin errors++; $display("FAIL op%h_step2: got %h expected %h", op[i], ctl0, e2[i]); end
      advance();
      checks++; if (ctl0 !== e3[i]) begin errors++; $display("FAIL op%h_step3: got %h expected %h", op[i], ctl0, e3[i]); end
      advance();
      checks++; if (ctl0 !== e4[i]) begin errors++; $display("FAIL op%h_step4: got %h expected %h", op[i], ctl0, e4[i]); end
      advance();
      checks++; if (if0.step !== 3'd0) begin errors++; $display("FAIL op%h_wrap: got %0d expected 0", op[i], if0.step); end
    end
  endtask

  task automatic test_cond_jump();
    logic [3:0]  op [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
    logic        fc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        fz [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] ex [4] = '{NONE, IO | J, NONE, IO | J};
    for (int i = 0; i < 4; i++) begin
      if0.opcode = op[i];
      if0.flag_c = fc[i];
      if0.flag_z = fz[i];
      advance();
      advance();
      checks++; if (ctl0 !== ex[i]) begin errors++; $display("FAIL jump[%0d]: got %h expected %h", i, ctl0, ex[i]); end
      advance();
      advance();
      advance();
    end
    if0.flag_c = 1'b0;
    if0.flag_z = 1'b0;
  endtask

  task automatic test_sta_stall();
    int ri_cycles;
    ri_cycles = 0;
    if0.opcode = 4'h4;
    advance();
    advance();
    advance();
    if0.run = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (if0.ri) ri_cycles++;
      checks++; if (if0.step !== 3'd3) begin errors++; $display("FAIL stall_step[%0d]: got %0d expected 3", i, if0.step); end
      checks++; if (ctl0 !== NONE) begin errors++; $display("FAIL stall_ctl[%0d]: got %h expected %h", i, ctl0, NONE); end
      advance();
    end
    if0.run = 1'b1;
    #1;
    if (if0.ri) ri_cycles++;
    checks++; if (ctl0 !== (AO | RI)) begin errors++; $display("FAIL resume_ctl: got %h expected %h", ctl0, AO | RI); end
    advance();
    if (if0.ri) ri_cycles++;
    checks++; if (if0.step !== 3'd4) begin errors++; $display("FAIL resume_step: got %0d expected 4", if0.step); end
    advance();
    if (if0.ri) ri_cycles++;
    checks++; if (ri_cycles !== 1) begin errors++; $display("FAIL ri_count: got %0d expected 1", ri_cycles); end
  endtask

  task automatic test_halt();
    if0.opcode = 4'hf;
    advance();
    advance();
    checks++; if (ctl0 !== HLT) begin errors++; $display("FAIL hlt_pulse: got %h expected %h", ctl0, HLT); end
    checks++; if (if0.halted !== 1'b0) begin errors++; $display("FAIL hlt_pre: got %b expected 0", if0.halted); end
    for (int i = 0; i < 12; i++) begin
      advance();
      checks++; if (if0.halted !== 1'b1 || if0.step !== 3'd2 || ctl0 !== NONE) begin
        errors++; $display("FAIL halted[%0d]: got halted=%b step=%0d ctl=%h expected 1/2/0000", i, if0.halted, if0.step, ctl0);
      end
      if0.run = (i % 3) != 1;
      if0.opcode = 4'(i);
    end
    if0.run = 1'b1;
    if0.opcode = 4'h0;
    rst_n = 1'b0;
    #1;
    checks++; if (if0.step !== 3'd0 || if0.halted !== 1'b0 || ctl0 !== NONE) begin
      errors++; $display("FAIL halt_reset: got step=%0d halted=%b ctl=%h expected 0/0/0000", if0.step, if0.halted, ctl0);
    end
    advance();
    rst_n = 1'b1;
    #1;
    checks++; if (ctl0 !== (CO | MI)) begin errors++; $display("FAIL halt_release: got %h expected %h", ctl0, CO | MI); end
    advance();
    checks++; if (if0.step !== 3'd1) begin errors++; $display("FAIL halt_restart: got %0d expected 1", if0.step); end
    if0.run = 1'b0;
  endtask

  task automatic test_early_end();
    logic [3:0]  op [18] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'ha, 4'ha, 4'ha,
                             4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4};
    logic [2:0]  es [18] = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0,
                             3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [15:0] ec [18] = '{RO | II | CE, IO | AI, CO | MI, RO | II | CE, IO | AI, CO | MI,
                             RO | II | CE, NONE, CO | MI,
                             RO | II | CE, IO | MI, RO | BI, EO | AI | FI, CO | MI,
                             RO | II | CE, IO | MI, AO | RI, CO | MI};
    if1.run = 1'b1;
    #1;
    checks++; if (if1.step !== 3'd0 || ctl1 !== (CO | MI)) begin
      errors++; $display("FAIL ee_start: got step=%0d ctl=%h expected 0/%h", if1.step, ctl1, CO | MI);
    end
    for (int i = 0; i < 18; i++) begin
      if1.opcode = op[i];
      advance();
      checks++; if (if1.step !== es[i]) begin errors++; $display("FAIL ee_step[%0d]: got %0d expected %0d", i, if1.step, es[i]); end
      checks++; if (ctl1 !== ec[i]) begin errors++; $display("FAIL ee_ctl[%0d]: got %h expected %h", i, ctl1, ec[i]); end
    end
    if1.run = 1'b0;
  endtask

  task automatic test_reset_mid();
    if0.opcode = 4'h2;
    if0.run = 1'b1;
    advance();
    checks++; if (ctl0 !== (IO | MI)) begin errors++; $display("FAIL mid_step2: got %h expected %h", ctl0, IO | MI); end
    advance();
    checks++; if (if0.step !== 3'd3 || ctl0 !== (RO | BI)) begin
      errors++; $display("FAIL mid_step3: got step=%0d ctl=%h expected 3/%h", if0.step, ctl0, RO | BI);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if0.step !== 3'd0 || ctl0 !== NONE) begin
      errors++; $display("FAIL mid_reset: got step=%0d ctl=%h expected 0/0000", if0.step, ctl0);
    end
    advance();
    checks++; if (if0.step !== 3'd0 || ctl0 !== NONE) begin
      errors++; $display("FAIL mid_held: got step=%0d ctl=%h expected 0/0000", if0.step, ctl0);
    end
    rst_n = 1'b1;
    #1;
    checks++; if (ctl0 !== (CO | MI)) begin errors++; $display("FAIL mid_release: got %h expected %h", ctl0, CO | MI); end
    advance();
    checks++; if (if0.step !== 3'd1 || ctl0 !== (RO | II | CE)) begin
      errors++; $display("FAIL mid_fetch: got step=%0d ctl=%h expected 1/%h", if0.step, ctl0, RO | II | CE);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_opcodes();
    test_cond_jump();
    test_sta_stall();
    test_halt();
    test_early_end();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
